// File: rtl/axil_cmd_master_pkg.sv
// Shared types and constants for the AXI-Lite command master.
package axil_cmd_master_pkg;

  // FSM state encoding
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_WR_REQ = 3'd1;
  localparam state_t ST_WR_RSP = 3'd2;
  localparam state_t ST_RD_REQ = 3'd3;
  localparam state_t ST_RD_RSP = 3'd4;
  localparam state_t ST_RSP    = 3'd5;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_0BAD;

  // Width of a counter that must hold 0..cycles. Never narrower than
  // one bit, so a disabled timeout (cycles == 0) still elaborates.
  function automatic int timer_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/axil_cmd_master_if.sv
// Command, response and AXI-Lite master signals of axil_cmd_master.
// Modport master is the block's view; modport slave is the
// environment's view (command source, response sink, AXI-Lite slave).
interface axil_cmd_master_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;

  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_awaddr;
  logic        m_wvalid;
  logic        m_wready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_bvalid;
  logic        m_bready;
  logic [1:0]  m_bresp;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_araddr;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  rsp_ready,
    output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    output m_arvalid, m_araddr, m_rready,
    input  m_awready, m_wready, m_bvalid, m_bresp,
    input  m_arready, m_rvalid, m_rdata, m_rresp
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output rsp_ready,
    input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    input  m_arvalid, m_araddr, m_rready,
    output m_awready, m_wready, m_bvalid, m_bresp,
    output m_arready, m_rvalid, m_rdata, m_rresp
  );

endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI-Lite master: turns one command into one
// single-beat read or write and returns one response, with a
// response-phase timeout.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a command (blocked while stale)
// WR_REQ | AW and W presented; each drops after its own handshake
// WR_RSP | waiting for B, timer running
// RD_REQ | AR presented until accepted
// RD_RSP | waiting for R, timer running
// RSP    | response held on rsp_* until rsp_ready
//
// stale marks a timed-out transaction whose B/R may still arrive; both
// bready and rready stay high so that late beat is absorbed and dropped
// before any new command is taken.
module axil_cmd_master
  import axil_cmd_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_main_a0,
  input  logic              rst_main_n,
  axil_cmd_master_if.master bus
);

  localparam int            TW       = timer_width(TIMEOUT_CYCLES);
  localparam bit            TMR_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TMR_SAT  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t        state_q, state_d;
  logic          stale_q, stale_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    resp_q, resp_d;
  logic          tmo_q, tmo_d;

  logic cmd_hs, aw_hs, w_hs, ar_hs, b_hs, r_hs, tmr_expire;

  // cmd_ready is gated by reset so it reads 0 while reset is held
  assign bus.cmd_ready   = rst_main_n && (state_q == ST_IDLE) && !stale_q;
  assign bus.m_awvalid   = (state_q == ST_WR_REQ) && !aw_done_q;
  assign bus.m_wvalid    = (state_q == ST_WR_REQ) && !w_done_q;
  assign bus.m_arvalid   = (state_q == ST_RD_REQ);
  assign bus.m_bready    = (state_q == ST_WR_RSP) || stale_q;
  assign bus.m_rready    = (state_q == ST_RD_RSP) || stale_q;
  assign bus.m_awaddr    = addr_q;
  assign bus.m_araddr    = addr_q;
  assign bus.m_wdata     = wdata_q;
  assign bus.m_wstrb     = wstrb_q;
  assign bus.rsp_valid   = (state_q == ST_RSP);
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_resp    = resp_q;
  assign bus.rsp_timeout = tmo_q;

  assign cmd_hs = bus.cmd_valid && bus.cmd_ready;
  assign aw_hs  = bus.m_awvalid && bus.m_awready;
  assign w_hs   = bus.m_wvalid && bus.m_wready;
  assign ar_hs  = bus.m_arvalid && bus.m_arready;
  assign b_hs   = bus.m_bvalid && bus.m_bready;
  assign r_hs   = bus.m_rvalid && bus.m_rready;

  // Expiry fires on the last permitted response cycle, so the response
  // state lasts exactly TIMEOUT_CYCLES cycles when nothing arrives.
  assign tmr_expire = TMR_EN && (timer_q == TMR_LAST);

  // Next-state, capture and response-register logic
  always_comb begin
    state_d   = state_q;
    stale_d   = stale_q;
    timer_d   = '0;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    tmo_d     = tmo_q;

    // A late beat from a timed-out transaction is swallowed here
    if (stale_q && (b_hs || r_hs)) begin
      stale_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_hs) begin
          addr_d    = bus.cmd_addr;
          wdata_d   = bus.cmd_wdata;
          wstrb_d   = bus.cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = bus.cmd_wr ? ST_WR_REQ : ST_RD_REQ;
        end
      end

      ST_WR_REQ: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = ST_WR_RSP;
        end
      end

      ST_RD_REQ: begin
        if (ar_hs) state_d = ST_RD_RSP;
      end

      ST_WR_RSP, ST_RD_RSP: begin
        if ((state_q == ST_WR_RSP) ? b_hs : r_hs) begin
          rdata_d = (state_q == ST_WR_RSP) ? 32'h0 : bus.m_rdata;
          resp_d  = (state_q == ST_WR_RSP) ? bus.m_bresp : bus.m_rresp;
          tmo_d   = 1'b0;
          state_d = ST_RSP;
        end else if (tmr_expire) begin
          rdata_d = TIMEOUT_RDATA;
          resp_d  = RESP_SLVERR;
          tmo_d   = 1'b1;
          stale_d = 1'b1;
          state_d = ST_RSP;
        end else begin
          timer_d = (timer_q == TMR_SAT) ? timer_q : timer_q + TW'(1);
        end
      end

      ST_RSP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, all cleared by reset
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      state_q   <= ST_IDLE;
      stale_q   <= 1'b0;
      timer_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      stale_q   <= stale_d;
      timer_q   <= timer_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      tmo_q     <= tmo_d;
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Testbench for axil_cmd_master: directed cases plus a randomized run.
// The reference model predicts every response from a byte-addressed
// memory image and the rule "a response slower than TMO cycles becomes
// a timeout response"; a monitor pops those predictions on each
// response handshake.
module tb_axil_cmd_master;
  import axil_cmd_master_pkg::*;

  localparam int TMO = 16;

  logic clk_main_a0 = 1'b0;
  logic rst_main_n  = 1'b0;

  always #5 clk_main_a0 = ~clk_main_a0;

  axil_cmd_master_if bus();

  axil_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_main_a0 (clk_main_a0),
    .rst_main_n  (rst_main_n),
    .bus         (bus)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } rsp_t;

  rsp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          bp_en   = 1'b0;
  int          hold_rsp = 0;
  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response sink and scoreboard
  initial begin : monitor
    rsp_t got;
    rsp_t held;
    bit   pend;
    pend = 1'b0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk_main_a0); #1;
      if (hold_rsp > 0) bus.rsp_ready = 1'b0;
      else              bus.rsp_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk_main_a0);
      if (!rst_main_n) begin
        pend = 1'b0;
        continue;
      end
      got = '{rdata: bus.rsp_rdata, resp: bus.rsp_resp, to: bus.rsp_timeout};
      if (pend) begin
        check("rsp_valid_held", 64'(bus.rsp_valid), 64'(1));
        check("rsp_stable", 64'(got), 64'(held));
      end
      pend = 1'b0;
      if (bus.rsp_valid) begin
        check("cmd_ready_during_rsp", 64'(bus.cmd_ready), 64'(0));
        if (bus.rsp_ready) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_rsp: got 0x%0h, want no response", got);
          end else begin
            rsp_t e;
            e = exp_q.pop_front();
            if (got !== e) begin
              n_fail++;
              $display("FAIL rsp_fields: got rdata=%h resp=%0d to=%0d, want rdata=%h resp=%0d to=%0d",
                       got.rdata, got.resp, got.to, e.rdata, e.resp, e.to);
            end
          end
        end else begin
          if (hold_rsp > 0) hold_rsp--;
          held = got;
          pend = 1'b1;
        end
      end
    end
  end

  // Present one command; pushes the prediction at the accepting edge
  task automatic issue_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input rsp_t e, input bit push);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_wstrb = s;
    while (!ok && n < 200) begin
      @(negedge clk_main_a0);
      ok = bus.cmd_ready;
      if (ok && push) exp_q.push_back(e);
      @(posedge clk_main_a0); #1;
      n++;
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'($urandom);
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
    bus.cmd_wstrb = 4'($urandom);
    check("cmd_accept", 64'(ok), 64'(1));
  endtask

  task automatic serve_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly);
    bit          aw_hs, w_hs;
    int          c;
    logic [31:0] sa, sd;
    logic [3:0]  ss;
    aw_hs = 1'b0; w_hs = 1'b0; c = 0;
    sa = '0; sd = '0; ss = '0;
    while (!(aw_hs && w_hs) && c < 200) begin
      bus.m_awready = !aw_hs && c >= aw_dly;
      bus.m_wready  = !w_hs && c >= w_dly;
      @(negedge clk_main_a0);
      check("awvalid", 64'(bus.m_awvalid), 64'(!aw_hs));
      check("wvalid", 64'(bus.m_wvalid), 64'(!w_hs));
      if (!aw_hs) check("awaddr", 64'(bus.m_awaddr), 64'(a));
      if (!w_hs)  check("wdata_wstrb", 64'({bus.m_wstrb, bus.m_wdata}), 64'({s, d}));
      if (bus.m_awvalid && bus.m_awready) begin aw_hs = 1'b1; sa = bus.m_awaddr; end
      if (bus.m_wvalid && bus.m_wready) begin
        w_hs = 1'b1; sd = bus.m_wdata; ss = bus.m_wstrb;
      end
      @(posedge clk_main_a0); #1;
      c++;
    end
    bus.m_awready = 1'b0;
    bus.m_wready  = 1'b0;
    check("aw_w_done", 64'(aw_hs && w_hs), 64'(1));
    slv_mem[sa] = merge(slv_mem.exists(sa) ? slv_mem[sa] : init_word(sa), sd, ss);
  endtask

  task automatic serve_ar(input logic [31:0] a, input int dly, output logic [31:0] rd);
    bit hs;
    int c;
    hs = 1'b0; c = 0; rd = '0;
    while (!hs && c < 200) begin
      bus.m_arready = c >= dly;
      @(negedge clk_main_a0);
      check("arvalid", 64'(bus.m_arvalid), 64'(1));
      check("araddr", 64'(bus.m_araddr), 64'(a));
      if (bus.m_arvalid && bus.m_arready) begin
        hs = 1'b1;
        rd = slv_mem.exists(bus.m_araddr) ? slv_mem[bus.m_araddr] : init_word(bus.m_araddr);
      end
      @(posedge clk_main_a0); #1;
      c++;
    end
    bus.m_arready = 1'b0;
    check("ar_done", 64'(hs), 64'(1));
  endtask

  // B or R channel: the beat appears after dly response-phase cycles
  task automatic serve_resp(input bit wr, input int dly, input logic [1:0] resp,
                            input logic [31:0] rd);
    bit hs, tmo;
    int i;
    hs = 1'b0; i = 0;
    tmo = (dly >= TMO);
    while (!hs && i < 200) begin
      if (wr) begin
        bus.m_bvalid = (i >= dly);
        bus.m_bresp  = resp;
      end else begin
        bus.m_rvalid = (i >= dly);
        bus.m_rresp  = resp;
        bus.m_rdata  = rd;
      end
      @(negedge clk_main_a0);
      if (i == 0)
        check("req_valids_dropped",
              64'({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid}), 64'(0));
      if (i < TMO) begin
        check("chan_ready", 64'(wr ? bus.m_bready : bus.m_rready), 64'(1));
        check("rsp_valid_early", 64'(bus.rsp_valid), 64'(0));
      end else begin
        if (i == TMO) check("timeout_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        check("stale_cmd_stall", 64'(bus.cmd_ready), 64'(0));
      end
      hs = wr ? (bus.m_bvalid && bus.m_bready) : (bus.m_rvalid && bus.m_rready);
      @(posedge clk_main_a0); #1;
      i++;
    end
    bus.m_bvalid = 1'b0;
    bus.m_rvalid = 1'b0;
    check("resp_hs", 64'(hs), 64'(1));
    if (!tmo) begin
      @(negedge clk_main_a0);
      check("rsp_latency", 64'(bus.rsp_valid), 64'(1));
      @(posedge clk_main_a0); #1;
    end else if (!bp_en && hold_rsp == 0) begin
      @(negedge clk_main_a0);
      check("cmd_ready_after_stale", 64'(bus.cmd_ready), 64'(1));
      @(posedge clk_main_a0); #1;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly,
                          input logic [1:0] bresp);
    rsp_t e;
    ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : init_word(a), d, s);
    if (b_dly >= TMO) e = '{rdata: TIMEOUT_RDATA, resp: RESP_SLVERR, to: 1'b1};
    else              e = '{rdata: 32'h0, resp: bresp, to: 1'b0};
    issue_cmd(1'b1, a, d, s, e, 1'b1);
    serve_aw_w(a, d, s, aw_dly, w_dly);
    serve_resp(1'b1, b_dly, bresp, 32'h0);
  endtask

  task automatic do_read(input logic [31:0] a, input int ar_dly, input int r_dly,
                         input logic [1:0] rresp);
    rsp_t        e;
    logic [31:0] rd;
    if (r_dly >= TMO) e = '{rdata: TIMEOUT_RDATA, resp: RESP_SLVERR, to: 1'b1};
    else              e = '{rdata: ref_mem.exists(a) ? ref_mem[a] : init_word(a),
                            resp: rresp, to: 1'b0};
    issue_cmd(1'b0, a, $urandom, 4'($urandom), e, 1'b1);
    serve_ar(a, ar_dly, rd);
    serve_resp(1'b0, r_dly, rresp, rd);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rsp_t e0;
    bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0;   bus.cmd_wstrb = '0;
    bus.m_awready = 1'b0; bus.m_wready = 1'b0; bus.m_bvalid = 1'b0; bus.m_bresp = '0;
    bus.m_arready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0;    bus.m_rresp = '0;

    // reset state
    repeat (3) @(posedge clk_main_a0);
    @(negedge clk_main_a0);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    check("rst_axi_valids", 64'({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid}), 64'(0));
    check("rst_axi_readies", 64'({bus.m_bready, bus.m_rready}), 64'(0));
    check("rst_rsp", 64'({bus.rsp_valid, bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout}), 64'(0));
    @(posedge clk_main_a0); #1;
    rst_main_n = 1'b1;
    @(negedge clk_main_a0);
    check("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    @(posedge clk_main_a0); #1;

    // zero-wait write, then W accepted 3 cycles before AW
    do_write(32'h500, 32'h1234_5678, 4'hF, 0, 0, 0, RESP_OKAY);
    do_write(32'h504, 32'hCAFE_F00D, 4'h5, 3, 0, 2, RESP_OKAY);

    // read with 5 wait cycles on R
    slv_mem[32'h500] = 32'hA5A5_0001;
    ref_mem[32'h500] = 32'hA5A5_0001;
    do_read(32'h500, 0, 5, RESP_OKAY);

    // timeout boundaries: last allowed cycle, late read, late write
    do_read(32'h504, 1, TMO - 1, 2'b01);
    do_read(32'h500, 0, TMO + 4, RESP_OKAY);
    do_write(32'h508, 32'h0BAD_BEEF, 4'hC, 0, 1, TMO, RESP_OKAY);
    do_read(32'h508, 0, 0, RESP_OKAY);

    // consumer stall of 10 cycles
    hold_rsp = 10;
    do_read(32'h504, 0, 1, 2'b11);
    repeat (14) @(posedge clk_main_a0);
    #1;

    // reset while AW/W are waiting
    e0 = '{rdata: 32'h0, resp: 2'b00, to: 1'b0};
    issue_cmd(1'b1, 32'h50C, 32'h1111_2222, 4'hF, e0, 1'b0);
    @(negedge clk_main_a0);
    check("pre_rst_awvalid", 64'({bus.m_awvalid, bus.m_wvalid}), 64'(3));
    #2;
    rst_main_n = 1'b0;
    #1;
    check("async_rst_valids", 64'({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid}), 64'(0));
    check("async_rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    @(posedge clk_main_a0); #1;
    rst_main_n = 1'b1;
    @(negedge clk_main_a0);
    check("rst_release_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    @(posedge clk_main_a0); #1;
    do_write(32'h50C, 32'h3333_4444, 4'h3, 0, 0, 0, RESP_OKAY);
    do_read(32'h50C, 0, 0, RESP_OKAY);

    // randomized traffic with consumer backpressure
    bp_en = 1'b1;
    for (int t = 0; t < 150; t++) begin
      logic [31:0] a;
      int          rdly;
      a = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       rdly = TMO + int'($urandom_range(0, 4));
        1:       rdly = TMO - 1;
        default: rdly = int'($urandom_range(0, 5));
      endcase
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 4)), rdly, 2'($urandom));
      else
        do_read(a, int'($urandom_range(0, 4)), rdly, 2'($urandom));
    end

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk_main_a0);
    repeat (3) @(posedge clk_main_a0);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
